irq_ctrl: RTL

- Parametrised interrupt front-end for the RISCV core; replaces the fixed six raw request lines (A..F) with NUM_IRQ channels.
- Synchronises asynchronous board request pins, edge-detects them, and latches pending bits.
- Arbitrates by fixed priority and presents one request/ID to the CPU over a req/ack/done handshake.
- Sits between the FPGA input pins and the CPU's interrupt entry logic.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_ctrl_if.sv | 14 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the irq_ctrl interrupt front-end.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Channel 0 wins arbitration; higher indices lose to lower ones.
  localparam bit PRIO_INDEX0_HIGHEST = 1'b1;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side interrupt handshake: request/ID out, ack/done pulses back.
interface irq_ctrl_if import irq_pkg::*; #(
  parameter int NUM_IRQ = 6
);
  localparam int ID_W = id_width(NUM_IRQ);

  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic            int_ack;
  logic            int_done;

  modport master (output int_req, output int_id, input int_ack, input int_done);
  modport slave  (input int_req, input int_id, output int_ack, output int_done);
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-set encoder (index 0 has highest priority).
module irq_prio_enc #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic         o_found,
  output logic [W-1:0] o_idx
);
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = W'(i);
      end
    end
  end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front-end: sync, edge detect, pending latch, fixed-priority arbitration.
// Build option: IRQ_CTRL_NESTED_EN enables preemption from SERVICE by higher-priority channels.
module irq_ctrl import irq_pkg::*; #(
  parameter int NUM_IRQ     = 6,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  input  logic               i_cfg_we,
  input  logic [NUM_IRQ-1:0] i_cfg_wdata,
  irq_ctrl_if.master         cpu,
  output logic [NUM_IRQ-1:0] o_pend_out,
  output logic [NUM_IRQ-1:0] o_isr_out,
  output logic [NUM_IRQ-1:0] o_en_out,
  output logic [CNT_W-1:0]   o_lost_cnt
);
  localparam int ID_W = id_width(NUM_IRQ);

  irq_state_e         r_state, w_next;
  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] r_prev, r_pend, r_isr, r_en;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_lost;

  logic [NUM_IRQ-1:0] w_edge, w_clr_pend, w_retire, w_set_isr;
  logic               w_cand_found, w_isr_found, w_lost_hit;
  logic [ID_W-1:0]    w_cand_idx, w_isr_idx;
  logic               w_load_id, w_int_req;

  irq_prio_enc #(.N(NUM_IRQ), .W(ID_W)) u_cand_enc (
    .i_vec(r_pend & r_en), .o_found(w_cand_found), .o_idx(w_cand_idx));

  irq_prio_enc #(.N(NUM_IRQ), .W(ID_W)) u_isr_enc (
    .i_vec(r_isr), .o_found(w_isr_found), .o_idx(w_isr_idx));

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_clr_pend = (r_state == REQ && cpu.int_ack) ? (NUM_IRQ'(1) << r_id) : '0;
  assign w_set_isr  = w_clr_pend;
  assign w_retire   = (r_state == SERVICE && cpu.int_done && w_isr_found)
                      ? (NUM_IRQ'(1) << w_isr_idx) : '0;
  assign w_lost_hit = |(w_edge & r_pend & ~w_clr_pend);

  always_comb begin
    w_next    = r_state;
    w_load_id = 1'b0;
    w_int_req = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cand_found) begin
          w_load_id = 1'b1;
          w_next    = REQ;
        end
      end
      REQ: begin
        w_int_req = 1'b1;
        if (cpu.int_ack) w_next = SERVICE;
      end
      SERVICE: begin
        if (cpu.int_done) begin
          if ((r_isr & ~w_retire) == '0) w_next = IDLE;
        end
`ifdef IRQ_CTRL_NESTED_EN
        // Retirement takes precedence; a preempting candidate is re-seen next cycle.
        else if (w_cand_found && w_isr_found && (w_cand_idx < w_isr_idx)) begin
          w_load_id = 1'b1;
          w_next    = REQ;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
      r_pend <= '0;
      r_isr  <= '0;
      r_en   <= '1;
      r_id   <= '0;
      r_lost <= '0;
    end else begin
      r_sync[0] <= i_irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= r_sync[SYNC_STAGES-1];
      r_pend <= (r_pend & ~w_clr_pend) | w_edge;
      r_isr  <= (r_isr & ~w_retire) | w_set_isr;
      if (i_cfg_we) r_en <= i_cfg_wdata;
      if (w_load_id) r_id <= w_cand_idx;
      if (w_lost_hit && r_lost != '1) r_lost <= r_lost + 1'b1;
    end
  end

  assign cpu.int_req = w_int_req;
  assign cpu.int_id  = r_id;
  assign o_pend_out  = r_pend;
  assign o_isr_out   = r_isr;
  assign o_en_out    = r_en;
  assign o_lost_cnt  = r_lost;

endmodule
